// File: rtl/x_uart_tx_arb_pkg.sv
// Shared types and constants for the UART TX arbiter.
// Optional feature macro used by the block: X_UART_TX_ARB_LOCK_EN.
package x_uart_tx_arb_pkg;

    // Width of one requester byte / one UART frame payload.
    localparam int p_byte_w = 8;

    // IDLE: waiting for a requester; SEND: one frame outstanding at the UART.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_t;

endpackage

// File: rtl/x_uart_tx_arb_rr.sv
// Combinational round-robin picker. The search begins at the index just
// after i_last and wraps modulo p_n, so the last winner has the lowest
// priority. Indices at or above p_n are never produced.
module x_uart_tx_arb_rr #(
    parameter int p_n    = 4,
    parameter int p_id_w = $clog2(p_n)
) (
    input  logic [p_n-1:0]    i_req,
    input  logic [p_id_w-1:0] i_last,
    output logic [p_id_w-1:0] o_winner,
    output logic              o_any
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        int idx;
        idx      = 0;
        o_winner = i_last;
        o_any    = |i_req;
        for (int i = p_n; i >= 1; i--) begin
            idx = (int'(i_last) + i) % p_n;
            if (i_req[idx]) begin
                o_winner = p_id_w'(idx);
            end
        end
    end

endmodule

// File: rtl/x_uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between p_n requesters.
// The granted byte is registered and held to the UART for the whole frame;
// the UART's end-of-frame pulse is routed back to the granted requester.
// Optional feature: define X_UART_TX_ARB_LOCK_EN to add i_req_lock, which
// lets a requester keep the transmitter for a multi-byte message.
//
// Handshake: a requester holds i_req_valid until it sees its o_req_accept
// bit; its byte is sampled only on the grant edge. Toward the UART,
// o_tx_valid stays high with stable o_tx_data until i_tx_accept pulses.
module x_uart_tx_arb
    import x_uart_tx_arb_pkg::*;
#(
    parameter int p_n    = 4,
    parameter int p_id_w = $clog2(p_n)
) (
    input  logic                    i_clk,
    input  logic                    i_nrst,
    input  logic [p_n-1:0]          i_req_valid,
    input  logic [p_byte_w*p_n-1:0] i_req_data,
    output logic [p_n-1:0]          o_req_accept,
    output logic [p_byte_w-1:0]     o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_accept,
`ifdef X_UART_TX_ARB_LOCK_EN
    input  logic [p_n-1:0]          i_req_lock,
`endif
    output logic [p_id_w-1:0]       o_grant_id,
    output logic                    o_busy
);

    arb_state_t          state_q;
    arb_state_t          state_d;
    logic [p_byte_w-1:0] tx_data_q;
    logic [p_id_w-1:0]   grant_q;
    logic [p_n-1:0]      grant_onehot;
    logic [p_n-1:0]      cand;
    logic [p_id_w-1:0]   winner;
    logic                any_req;
    logic                grant_en;

    assign grant_onehot = {{(p_n-1){1'b0}}, 1'b1} << grant_q;
    assign grant_en     = (state_q == IDLE) && any_req;

`ifdef X_UART_TX_ARB_LOCK_EN
    logic lock_q;
    logic lock_own;
    logic accept_en;

    assign lock_own  = i_req_lock[grant_q];
    assign accept_en = (state_q == SEND) && i_tx_accept;

    // While the last winner holds its lock, only that requester is eligible.
    always_comb begin
        cand = i_req_valid;
        if (lock_q && lock_own) begin
            cand = i_req_valid & grant_onehot;
        end
    end

    // Lock is captured at frame end and released once the owner lowers it in IDLE.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            lock_q <= 1'b0;
        end else if (accept_en) begin
            lock_q <= lock_own;
        end else if ((state_q == IDLE) && !lock_own) begin
            lock_q <= 1'b0;
        end
    end
`else
    assign cand = i_req_valid;
`endif

    x_uart_tx_arb_rr #(
        .p_n    (p_n),
        .p_id_w (p_id_w)
    ) u_rr (
        .i_req    (cand),
        .i_last   (grant_q),
        .o_winner (winner),
        .o_any    (any_req)
    );

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: grant whenever someone is eligible, release on frame end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req)     state_d = SEND;
            SEND:    if (i_tx_accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: the accept pulse is combinational so it lines up with the UART's.
    always_comb begin
        o_tx_valid   = 1'b0;
        o_busy       = 1'b0;
        o_req_accept = '0;
        if (state_q == SEND) begin
            o_tx_valid = 1'b1;
            o_busy     = 1'b1;
            if (i_tx_accept) begin
                o_req_accept = grant_onehot;
            end
        end
    end

    // Capture winner byte and index on the grant edge; frozen for the frame.
    // Reset index is p_n-1 so requester 0 is searched first.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            tx_data_q <= '0;
            grant_q   <= p_id_w'(p_n - 1);
        end else if (grant_en) begin
            tx_data_q <= i_req_data[int'(winner)*p_byte_w +: p_byte_w];
            grant_q   <= winner;
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_grant_id = grant_q;

endmodule
